// File: rtl/bus_arbiter_2ch_pkg.sv
// Shared definitions for the two-channel bus arbiter.
// Holds the FSM state encodings and the burst counter width so the
// arbiter and anything inspecting it agree on them.
package bus_arbiter_2ch_pkg;

  // State encodings (legacy-compatible fixed values)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  // Burst counter width; enough for MAX_BURST up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/bus_arbiter_2ch_mux.sv
// N-bit 2:1 bus multiplexer used as the arbiter output data path.
// Ports:
//   in0, in1 : N-bit data inputs
//   sel      : 0 selects in0, 1 selects in1
//   out      : selected data, purely combinational
module N_bus_2_1_mux #(
  parameter int N = 8
) (
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic         sel,
  output logic [N-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/bus_arbiter_2ch.sv
// Two-requester bus arbiter with bounded bursts.
// A requester is granted the shared bus and keeps it for up to MAX_BURST
// transfers while the other requester waits; ties from IDLE go to the
// requester that was not granted last. Data is never dropped while the
// downstream stalls (out_ready=0): the grant and counter simply hold.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   req0/req1        : requester has a word
//   in0/in1          : requester data
//   out_ready        : downstream accepts the word this cycle
//   gnt0/gnt1        : bus ownership
//   out_valid, out   : shared data bus and its valid
//   sel              : registered mux select (0 = in0, 1 = in1)
//
// state     | meaning
// ----------+------------------------------------------
// IDLE      | nobody owns the bus, sel holds last value
// GRANT0    | requester 0 owns the bus
// GRANT1    | requester 1 owns the bus
module bus_arbiter_2ch
  import bus_arbiter_2ch_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic         out_ready,
  output logic         gnt0,
  output logic         gnt1,
  output logic         out_valid,
  output logic [N-1:0] out,
  output logic         sel
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last;
  logic [CNT_W-1:0] count;
  logic             xfer;
  logic             burst_done;
  logic             grant_entry;

  assign gnt0       = (state == ST_GRANT0);
  assign gnt1       = (state == ST_GRANT1);
  assign out_valid  = (gnt0 & req0) | (gnt1 & req1);
  assign xfer       = out_valid & out_ready;
  assign burst_done = xfer && (count == BURST_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req0 && req1)
          state_nxt = last ? ST_GRANT0 : ST_GRANT1;
        else if (req0)
          state_nxt = ST_GRANT0;
        else if (req1)
          state_nxt = ST_GRANT1;
      end
      ST_GRANT0: begin
        // A dropped request takes priority over the burst limit.
        if (!req0)
          state_nxt = req1 ? ST_GRANT1 : ST_IDLE;
        else if (burst_done && req1)
          state_nxt = ST_GRANT1;
      end
      ST_GRANT1: begin
        if (!req1)
          state_nxt = req0 ? ST_GRANT0 : ST_IDLE;
        else if (burst_done && req0)
          state_nxt = ST_GRANT0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Entering a grant from IDLE or from the other grant; staying in the
  // same grant after a full burst is not an entry (counter wraps instead).
  assign grant_entry = (state_nxt != state) && (state_nxt != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (grant_entry) begin
        count <= '0;
        last  <= (state_nxt == ST_GRANT1);
        sel   <= (state_nxt == ST_GRANT1);
      end else if (xfer) begin
        count <= burst_done ? '0 : count + CNT_W'(1);
      end
    end
  end

  N_bus_2_1_mux #(.N(N)) u_mux (
    .in0 (in0),
    .in1 (in1),
    .sel (sel),
    .out (out)
  );

endmodule

// File: doc/bus_arbiter_2ch.md
BUS_ARBITER_2CH -- requirements
Module: bus_arbiter_2ch

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the data bus width in bits.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, giving the maximum transfers per grant while the other requester waits (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port req0, input, 1: requester 0 has a word to send.
REQ-006 The block SHALL have port req1, input, 1: requester 1 has a word to send.
REQ-007 The block SHALL have port in0, input, N: requester 0 data, valid while req0=1.
REQ-008 The block SHALL have port in1, input, N: requester 1 data, valid while req1=1.
REQ-009 The block SHALL have port out_ready, input, 1: downstream accepts the word this cycle.
REQ-010 The block SHALL have port gnt0, output, 1: requester 0 owns the bus; a word is consumed when gnt0 & req0 & out_ready.
REQ-011 The block SHALL have port gnt1, output, 1: requester 1 owns the bus; a word is consumed when gnt1 & req1 & out_ready.
REQ-012 The block SHALL have port out_valid, output, 1: out carries a valid word.
REQ-013 The block SHALL have port out, output, N: shared data bus.
REQ-014 The block SHALL have port sel, output, 1: current mux select (0 = in0, 1 = in1).

Function
REQ-015 FSM states SHALL be IDLE, GRANT0 and GRANT1; gnt0=1 only in GRANT0, gnt1=1 only in GRANT1, never both.
REQ-016 sel SHALL be registered: 0 in GRANT0, 1 in GRANT1, held at its last value in IDLE.
REQ-017 out SHALL equal in1 when sel=1, else in0, combinationally.
REQ-018 out_valid SHALL be (gnt0 & req0) | (gnt1 & req1); out_valid=0 in IDLE.
REQ-019 Transfer (xfer) SHALL be defined as out_valid & out_ready.
REQ-020 IDLE: req0 only -> GRANT0; req1 only -> GRANT1; both -> requester not in register last; neither -> stay.
REQ-021 Grant latency SHALL be exactly one cycle: a request sampled in IDLE at edge t gives gnt at edge t+1.
REQ-022 last SHALL update to the granted index on every entry to GRANT0/GRANT1.
REQ-023 A 4-bit burst counter SHALL clear on grant entry and increment on each xfer.
REQ-024 GRANTk with reqk=0: next state SHALL be GRANTother if req of the other requester=1, else IDLE.
REQ-025 GRANTk with xfer and count=MAX_BURST-1: next state SHALL be GRANTother if the other requester requests, else remain GRANTk with count cleared.
REQ-026 Other GRANTk cycles (stalled by out_ready=0 or count below limit) SHALL remain in GRANTk; data SHALL NOT be dropped while out_ready=0.
REQ-027 Simultaneous reqk drop and burst limit SHALL follow REQ-024.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, gnt0=0, gnt1=0, out_valid=0, sel=0, count=0, last=1 (requester 0 wins the first tie).
REQ-029 Reset mid-burst SHALL abort the grant without completing the burst; the first grant after rst falls follows REQ-020.

Structure
REQ-030 State encodings (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2) and the counter width SHALL live in the shared package.
REQ-031 The output data path SHALL instantiate the existing N_bus_2_1_mux (parameter N) as its single sub-module, driven by sel.

Verification
REQ-032 Reset, req0=1 only, out_ready=1, in0=8'hA5: gnt0=1 one cycle after req0, out=8'hA5, out_valid=1, sel=0.
REQ-033 req0=req1=1 continuously, out_ready=1, MAX_BURST=4: grants alternate 4 xfers to 0, then 4 to 1, repeating; requester 0 goes first.
REQ-034 GRANT1 with out_ready=0 for 5 cycles: gnt1 held, count unchanged, out stable = in1, no switch to requester 0.
REQ-035 GRANT0, req0 drops after 2 xfers, req1=1: next cycle gnt1=1, sel=1, count=0.
REQ-036 rst asserted mid-burst in GRANT1 (count=2): outputs go to reset values in the same cycle; after release with both requesting, gnt0 wins.
REQ-037 Random req/out_ready for 10k cycles: never gnt0&gnt1; every out_valid&out_ready matches the granted input word.
